// File: rtl/arb_mux2_1_pkg.sv
// Shared types and defaults for the registered two-input arbitrating selector.
package arb_mux2_1_pkg;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_B = 1'b1
    } src_e;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/arb_mux2_1_if.sv
// Stream bundle for arb_mux2_1: two producer channels, one consumer channel, grant counters.
interface arb_mux2_1_if #(
    parameter int WIDTH = arb_mux2_1_pkg::DEF_WIDTH,
    parameter int CNT_W = arb_mux2_1_pkg::DEF_CNT_W
);
    logic             a_valid;
    logic [WIDTH-1:0] a_data;
    logic             a_ready;
    logic             b_valid;
    logic [WIDTH-1:0] b_data;
    logic             b_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_sel;
    logic             out_ready;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    // Environment side: producers and the downstream consumer.
    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, out_valid, out_data, out_sel, cnt_a, cnt_b
    );

    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, out_valid, out_data, out_sel, cnt_a, cnt_b
    );
endinterface

// File: rtl/arb_mux2_1_rr_arb2.sv
// Two-requester arbiter: combinational one-hot grant plus the last-winner pointer.
module rr_arb2
    import arb_mux2_1_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_mode,
    input  logic       i_advance,
    output logic [1:0] o_gnt
);

    src_e r_last_sel;

    // Reset to B so that A wins the first contested cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_sel <= SRC_B;
        end else if (i_advance) begin
            r_last_sel <= o_gnt[1] ? SRC_B : SRC_A;
        end
    end

    always_comb begin
        o_gnt = 2'b00;
        case (i_req)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = (i_mode && (r_last_sel == SRC_A)) ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/arb_mux2_1.sv
// Registered 2:1 stream selector: arbitrates A/B into a one-beat output register
// and counts beats accepted from each input.
module arb_mux2_1
    import arb_mux2_1_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int RR    = 1,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    arb_mux2_1_if.slave   bus
);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    src_e             r_out_sel;
    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;

    logic       w_load_en;
    logic [1:0] w_req;
    logic [1:0] w_gnt;
    logic       w_advance;

    assign w_load_en = !r_out_valid || bus.out_ready;
    // Requests are masked during reset so both readies stay low while rst_n is asserted.
    assign w_req     = {bus.b_valid, bus.a_valid} & {2{w_load_en & rst_n}};
    assign w_advance = |w_gnt;

    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (w_req),
        .i_mode    (RR != 0),
        .i_advance (w_advance),
        .o_gnt     (w_gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= SRC_A;
            r_cnt_a     <= '0;
            r_cnt_b     <= '0;
        end else if (w_advance) begin
            r_out_valid <= 1'b1;
            if (w_gnt[1]) begin
                r_out_data <= bus.b_data;
                r_out_sel  <= SRC_B;
                r_cnt_b    <= r_cnt_b + CNT_W'(1);
            end else begin
                r_out_data <= bus.a_data;
                r_out_sel  <= SRC_A;
                r_cnt_a    <= r_cnt_a + CNT_W'(1);
            end
        end else if (w_load_en) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.a_ready   = w_gnt[0];
    assign bus.b_ready   = w_gnt[1];
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;
    assign bus.cnt_a     = r_cnt_a;
    assign bus.cnt_b     = r_cnt_b;

endmodule

// File: tb/tb_arb_mux2_1.sv
// Bench for arb_mux2_1: round-robin/16-bit-counter instance and fixed-priority/4-bit-counter
// instance, both checked every cycle against a transaction-level model.
module tb_arb_mux2_1;

    logic clk;
    logic rst_n;

    logic       av[2], bv[2], ordy[2];
    logic [7:0] ad[2], bd[2];

    logic        ov[2], os[2], ar[2], br[2];
    logic [7:0]  od[2];
    logic [15:0] ca[2], cb[2];

    int n_cmp = 0;
    int n_bad = 0;

    // Model state per instance
    bit         m_ov[2];
    logic [7:0] m_od[2];
    bit         m_os[2];
    bit         m_last[2];
    int         m_ca[2], m_cb[2];
    bit         acc_a[2], acc_b[2];
    logic       lbr[2];
    int         rrm[2]   = '{1, 0};
    int         cmask[2] = '{32'hFFFF, 32'hF};
    logic [7:0] seq[6]   = '{8'h11, 8'h22, 8'h11, 8'h22, 8'h11, 8'h22};

    arb_mux2_1_if #(.WIDTH(8), .CNT_W(16)) i0 ();
    arb_mux2_1_if #(.WIDTH(8), .CNT_W(4))  i1 ();

    arb_mux2_1 #(.WIDTH(8), .RR(1), .CNT_W(16)) dut0 (.clk(clk), .rst_n(rst_n), .bus(i0));
    arb_mux2_1 #(.WIDTH(8), .RR(0), .CNT_W(4))  dut1 (.clk(clk), .rst_n(rst_n), .bus(i1));

    assign i0.a_valid = av[0];  assign i0.a_data = ad[0];
    assign i0.b_valid = bv[0];  assign i0.b_data = bd[0];
    assign i0.out_ready = ordy[0];
    assign i1.a_valid = av[1];  assign i1.a_data = ad[1];
    assign i1.b_valid = bv[1];  assign i1.b_data = bd[1];
    assign i1.out_ready = ordy[1];

    assign ov[0] = i0.out_valid; assign od[0] = i0.out_data; assign os[0] = i0.out_sel;
    assign ar[0] = i0.a_ready;   assign br[0] = i0.b_ready;
    assign ca[0] = i0.cnt_a;     assign cb[0] = i0.cnt_b;
    assign ov[1] = i1.out_valid; assign od[1] = i1.out_data; assign os[1] = i1.out_sel;
    assign ar[1] = i1.a_ready;   assign br[1] = i1.b_ready;
    assign ca[1] = {12'b0, i1.cnt_a};
    assign cb[1] = {12'b0, i1.cnt_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ov[d] = 0; m_od[d] = 8'h00; m_os[d] = 0; m_last[d] = 1;
            m_ca[d] = 0; m_cb[d] = 0; acc_a[d] = 0; acc_b[d] = 0;
        end
    endtask

    // One clock: check both instances mid-cycle, advance the model, return just after the edge.
    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            int g;
            g = -1;
            if (!rst_n) begin
                m_ov[d] = 0; m_od[d] = 8'h00; m_os[d] = 0; m_last[d] = 1;
                m_ca[d] = 0; m_cb[d] = 0;
            end else if (!m_ov[d] || ordy[d]) begin
                if (av[d] && bv[d]) g = (rrm[d] != 0 && m_last[d] == 0) ? 1 : 0;
                else if (av[d])     g = 0;
                else if (bv[d])     g = 1;
            end
            chk($sformatf("d%0d out_valid", d), 32'(ov[d]), 32'(m_ov[d]));
            chk($sformatf("d%0d out_data", d),  32'(od[d]), 32'(m_od[d]));
            chk($sformatf("d%0d out_sel", d),   32'(os[d]), 32'(m_os[d]));
            chk($sformatf("d%0d cnt_a", d),     32'(ca[d]), 32'(m_ca[d]));
            chk($sformatf("d%0d cnt_b", d),     32'(cb[d]), 32'(m_cb[d]));
            chk($sformatf("d%0d a_ready", d),   32'(ar[d]), 32'(g == 0));
            chk($sformatf("d%0d b_ready", d),   32'(br[d]), 32'(g == 1));
            lbr[d]   = br[d];
            acc_a[d] = (g == 0);
            acc_b[d] = (g == 1);
            if (g >= 0) begin
                m_ov[d]   = 1;
                m_od[d]   = (g == 1) ? bd[d] : ad[d];
                m_os[d]   = (g == 1);
                m_last[d] = (g == 1);
                if (g == 1) m_cb[d] = (m_cb[d] + 1) & cmask[d];
                else        m_ca[d] = (m_ca[d] + 1) & cmask[d];
            end else if (rst_n && ordy[d]) begin
                m_ov[d] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            av[d] = 1; bv[d] = 1; ad[d] = 8'h11; bd[d] = 8'h22; ordy[d] = 1;
        end

        // Reset held with both inputs valid
        tick();
        tick();
        rst_n = 1'b1;

        // Round-robin on dut0, fixed priority on dut1, both always valid
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_seq", 32'(od[0]), 32'(seq[k]));
            chk("fp_seq", 32'(od[1]), 32'h11);
            if (k == 0) chk("first_sel", 32'(os[0]), 32'h0);
            if (k == 3) begin
                chk("fp_cnt_a", 32'(ca[1]), 32'd4);
                chk("fp_cnt_b", 32'(cb[1]), 32'd0);
            end
        end
        chk("rr_cnt_a", 32'(ca[0]), 32'd3);
        chk("rr_cnt_b", 32'(cb[0]), 32'd3);

        // Backpressure on dut0
        av[1] = 0; bv[1] = 0;
        av[0] = 1; bv[0] = 0; ad[0] = 8'h5A; ordy[0] = 1;
        tick();
        chk("bp_load", 32'(od[0]), 32'h5A);
        av[0] = 0; bv[0] = 1; bd[0] = 8'hC3; ordy[0] = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_hold_data", 32'(od[0]), 32'h5A);
            chk("bp_hold_valid", 32'(ov[0]), 32'h1);
        end
        ordy[0] = 1;
        tick();
        chk("bp_b_ready", 32'(lbr[0]), 32'h1);
        chk("bp_b_data", 32'(od[0]), 32'hC3);
        chk("bp_b_sel", 32'(os[0]), 32'h1);
        bv[0] = 0;

        // Counter wrap: A-only beats after a fresh reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            av[d] = 1; bv[d] = 0; ordy[d] = 1;
        end
        for (int k = 1; k <= 17; k++) begin
            ad[0] = 8'($urandom); ad[1] = 8'($urandom);
            tick();
            if (k == 15) chk("wrap_15", 32'(ca[1]), 32'hF);
            if (k == 16) chk("wrap_16", 32'(ca[1]), 32'h0);
            if (k == 17) chk("wrap_17", 32'(ca[1]), 32'h1);
        end

        // Randomized traffic, producers hold until accepted
        for (int k = 0; k < 400; k++) begin
            for (int d = 0; d < 2; d++) begin
                if (!av[d] || acc_a[d]) begin av[d] = 1'($urandom_range(0, 1)); ad[d] = 8'($urandom); end
                if (!bv[d] || acc_b[d]) begin bv[d] = 1'($urandom_range(0, 1)); bd[d] = 8'($urandom); end
                ordy[d] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end

        // Async reset while stalled
        av[0] = 1; bv[0] = 0; ad[0] = 8'hE7; ordy[0] = 1;
        tick();
        ordy[0] = 0;
        tick();
        chk("stall_valid", 32'(ov[0]), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(ov[0]), 32'h0);
        chk("async_cnt_a", 32'(ca[0]), 32'h0);
        chk("async_cnt_b", 32'(cb[0]), 32'h0);
        chk("async_a_ready", 32'(ar[0]), 32'h0);
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
